// File: rtl/pwr_retry_sched.sv
// pwr_retry_sched: supervises the master power sequencer, restarting it on a fault with
// exponential backoff and latching a lockout once the retry budget is spent.
module pwr_retry_sched #(
    parameter int NUM_FLT   = 7,
    parameter int MAX_RETRY = 3,
    parameter int BASE_MS   = 1000,
    parameter int STABLE_MS = 10000,
    parameter int RST_CYC   = 8
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iTick_1ms,
    input  logic               iPwr_Req,
    input  logic [NUM_FLT-1:0] iSeq_Flt_N,
    input  logic               iClr_Lockout,
    output logic               oSeq_En,
    output logic               oSeq_Rst_N,
    output logic [3:0]         oRetry_Cnt,
    output logic [NUM_FLT-1:0] oFirst_Flt,
    output logic               oLockout,
    output logic [2:0]         oState
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        RESTART = 3'd2,
        BACKOFF = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    localparam int STB_W = $clog2(STABLE_MS + 1);
    localparam int RC_W  = $clog2(RST_CYC + 1);

    state_t             state_r;
    logic               seqEn_r;
    logic               seqRstN_r;
    logic               lockout_r;
    logic [3:0]         retryCnt_r;
    logic [NUM_FLT-1:0] firstFlt_r;
    logic [STB_W-1:0]   stableCnt_r;
    logic [RC_W-1:0]    rstCnt_r;
    logic [15:0]        msCnt_r;

    logic               anyFlt_s;
    logic [3:0]         retryInc_s;
    logic [NUM_FLT-1:0] fltHeld_s;
    logic [NUM_FLT-1:0] fltCapt_s;
    logic [STB_W-1:0]   stableNext_s;
    logic               stableHit_s;
    logic [15:0]        backoffLoad_s;

    // Backoff length in ms for a given retry count, doubling per retry and clamped to 16 bits.
    function automatic logic [15:0] backoffMs(input logic [3:0] cnt);
        logic [47:0] v;
        logic [3:0]  sh;
        if (cnt == 4'd0) begin
            sh = 4'd0;
        end else begin
            sh = cnt - 4'd1;
        end
        v = 48'(BASE_MS) << sh;
        if (v > 48'h0000_0000_FFFF) begin
            return 16'hFFFF;
        end else begin
            return v[15:0];
        end
    endfunction

    // Next-value helpers shared by the state machine.
    always_comb begin
        anyFlt_s = ~&iSeq_Flt_N;
        if (retryCnt_r == 4'hF) begin
            retryInc_s = 4'hF;
        end else begin
            retryInc_s = retryCnt_r + 4'd1;
        end
        // A clear in the same cycle as a new fault makes room for the new capture.
        if (iClr_Lockout) begin
            fltHeld_s = {NUM_FLT{1'b0}};
        end else begin
            fltHeld_s = firstFlt_r;
        end
        if (fltHeld_s == {NUM_FLT{1'b0}}) begin
            fltCapt_s = ~iSeq_Flt_N;
        end else begin
            fltCapt_s = fltHeld_s;
        end
        stableNext_s  = stableCnt_r + STB_W'(1);
        stableHit_s   = (stableNext_s == STB_W'(STABLE_MS));
        backoffLoad_s = backoffMs(retryCnt_r);
    end

    // Supervisor state machine with all outputs registered.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_r     <= IDLE;
            seqEn_r     <= 1'b0;
            seqRstN_r   <= 1'b0;
            lockout_r   <= 1'b0;
            retryCnt_r  <= 4'd0;
            firstFlt_r  <= {NUM_FLT{1'b0}};
            stableCnt_r <= {STB_W{1'b0}};
            rstCnt_r    <= {RC_W{1'b0}};
            msCnt_r     <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    seqEn_r    <= 1'b0;
                    seqRstN_r  <= 1'b1;
                    firstFlt_r <= fltHeld_s;
                    // Wait for the sequencer reset to deassert before enabling it.
                    if (iPwr_Req && seqRstN_r) begin
                        state_r     <= RUN;
                        seqEn_r     <= 1'b1;
                        stableCnt_r <= {STB_W{1'b0}};
                    end
                end
                RUN: begin
                    if (anyFlt_s) begin
                        state_r    <= RESTART;
                        seqEn_r    <= 1'b0;
                        seqRstN_r  <= 1'b0;
                        rstCnt_r   <= {RC_W{1'b0}};
                        retryCnt_r <= retryInc_s;
                        firstFlt_r <= fltCapt_s;
                    end else begin
                        firstFlt_r <= fltHeld_s;
                        if (iTick_1ms && (stableCnt_r != STB_W'(STABLE_MS))) begin
                            stableCnt_r <= stableNext_s;
                            if (stableHit_s) begin
                                retryCnt_r <= 4'd0;
                            end
                        end
                        if (!iPwr_Req) begin
                            state_r <= IDLE;
                            seqEn_r <= 1'b0;
                        end
                    end
                end
                RESTART: begin
                    firstFlt_r <= fltHeld_s;
                    if (rstCnt_r == RC_W'(RST_CYC - 1)) begin
                        seqRstN_r <= 1'b1;
                        if (retryCnt_r >= 4'(MAX_RETRY)) begin
                            state_r   <= LOCKOUT;
                            lockout_r <= 1'b1;
                        end else begin
                            state_r <= BACKOFF;
                            msCnt_r <= backoffLoad_s;
                        end
                    end else begin
                        rstCnt_r <= rstCnt_r + RC_W'(1);
                    end
                end
                BACKOFF: begin
                    firstFlt_r <= fltHeld_s;
                    if (msCnt_r == 16'd0) begin
                        if (iPwr_Req) begin
                            state_r     <= RUN;
                            seqEn_r     <= 1'b1;
                            stableCnt_r <= {STB_W{1'b0}};
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (iTick_1ms) begin
                        msCnt_r <= msCnt_r - 16'd1;
                    end
                end
                LOCKOUT: begin
                    if (iClr_Lockout) begin
                        state_r    <= IDLE;
                        lockout_r  <= 1'b0;
                        retryCnt_r <= 4'd0;
                        firstFlt_r <= {NUM_FLT{1'b0}};
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    seqEn_r   <= 1'b0;
                    seqRstN_r <= 1'b1;
                    lockout_r <= 1'b0;
                end
            endcase
        end
    end

    assign oSeq_En    = seqEn_r;
    assign oSeq_Rst_N = seqRstN_r;
    assign oRetry_Cnt = retryCnt_r;
    assign oFirst_Flt = firstFlt_r;
    assign oLockout   = lockout_r;
    assign oState     = state_r;

    pwr_retry_sched_chk uChk (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iSeq_En   (seqEn_r),
        .iSeq_Rst_N(seqRstN_r),
        .iLockout  (lockout_r),
        .iState    (state_r)
    );

endmodule

// pwr_retry_sched_chk: invariants tying the registered outputs to the supervisor state.
module pwr_retry_sched_chk (
    input logic       iClk,
    input logic       iRst_n,
    input logic       iSeq_En,
    input logic       iSeq_Rst_N,
    input logic       iLockout,
    input logic [2:0] iState
);

    aEnOnlyInRun : assert property (@(posedge iClk) disable iff (!iRst_n)
        iSeq_En == (iState == 3'd1));

    aLockoutOnlyInLockout : assert property (@(posedge iClk) disable iff (!iRst_n)
        iLockout == (iState == 3'd4));

    aNoEnDuringReset : assert property (@(posedge iClk) disable iff (!iRst_n)
        !(iSeq_En && !iSeq_Rst_N));

    aLegalState : assert property (@(posedge iClk) disable iff (!iRst_n)
        iState <= 3'd4);

endmodule

// File: tb/tb_pwr_retry_sched.sv
// tb_pwr_retry_sched: scoreboard bench for the power retry supervisor; expectations are
// queued as stimulus is applied and compared as the design responds.
`timescale 1ns/1ps
module tb_pwr_retry_sched;

    localparam int NF = 7;
    localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_RESTART = 3'd2,
                           S_BACKOFF = 3'd3, S_LOCKOUT = 3'd4;

    logic          iClk = 1'b0;
    logic          iRst_n;
    logic          iTick_1ms;
    logic          iPwr_Req;
    logic [NF-1:0] iSeq_Flt_N;
    logic          iClr_Lockout;
    logic          oSeq_En;
    logic          oSeq_Rst_N;
    logic [3:0]    oRetry_Cnt;
    logic [NF-1:0] oFirst_Flt;
    logic          oLockout;
    logic [2:0]    oState;

    int          errCnt = 0;
    int          chkCnt = 0;
    logic        tickEn;
    logic        tickPh;
    logic [31:0] expQ[$];

    always #5 iClk = ~iClk;

    pwr_retry_sched #(
        .NUM_FLT(NF), .MAX_RETRY(3), .BASE_MS(1000), .STABLE_MS(10000), .RST_CYC(8)
    ) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iTick_1ms(iTick_1ms), .iPwr_Req(iPwr_Req),
        .iSeq_Flt_N(iSeq_Flt_N), .iClr_Lockout(iClr_Lockout), .oSeq_En(oSeq_En),
        .oSeq_Rst_N(oSeq_Rst_N), .oRetry_Cnt(oRetry_Cnt), .oFirst_Flt(oFirst_Flt),
        .oLockout(oLockout), .oState(oState)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input logic [31:0] v);
        expQ.push_back(v);
    endtask

    task automatic popChk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (expQ.size() == 0) begin
            errCnt++;
            $display("FAIL %s: scoreboard empty, got 0x%0h", tag, obs);
        end else begin
            e = expQ.pop_front();
            checkVal(tag, obs, e);
        end
    endtask

    // One clock: inputs for the next cycle are set 1 ns after the edge, outputs read then.
    task automatic cyc();
        @(posedge iClk);
        #1;
        tickPh    = ~tickPh;
        iTick_1ms = tickEn & tickPh;
    endtask

    task automatic waitLeave(input logic [2:0] st, input int budget,
                             output int ticks, output int cycles, output int lows);
        ticks  = 0;
        cycles = 0;
        lows   = 0;
        while (oState == st && cycles < budget) begin
            if (iTick_1ms) ticks++;
            if (!oSeq_Rst_N) lows++;
            cyc();
            cycles++;
        end
        checkVal("left_state", {31'b0, oState != st}, 32'd1);
    endtask

    task automatic faultPulse(input logic [NF-1:0] mask);
        iSeq_Flt_N = ~mask;
        cyc();
        iSeq_Flt_N = {NF{1'b1}};
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int tk, cy, lo, n;
        logic done;
        iRst_n       = 1'b0;
        iPwr_Req     = 1'b0;
        iSeq_Flt_N   = {NF{1'b1}};
        iClr_Lockout = 1'b0;
        iTick_1ms    = 1'b0;
        tickEn       = 1'b0;
        tickPh       = 1'b0;
        repeat (3) cyc();

        checkVal("rst_en",    oSeq_En,    32'd0);
        checkVal("rst_rstn",  oSeq_Rst_N, 32'd0);
        checkVal("rst_retry", oRetry_Cnt, 32'd0);
        checkVal("rst_first", oFirst_Flt, 32'd0);
        checkVal("rst_lock",  oLockout,   32'd0);
        checkVal("rst_state", oState,     32'(S_IDLE));

        // Power-up: RUN two clocks after reset release.
        iPwr_Req = 1'b1;
        iRst_n   = 1'b1;
        cyc();
        checkVal("t1_rstn_c1",  oSeq_Rst_N, 32'd1);
        checkVal("t1_state_c1", oState,     32'(S_IDLE));
        cyc();
        checkVal("t1_state_c2", oState,     32'(S_RUN));
        checkVal("t1_en",       oSeq_En,    32'd1);
        checkVal("t1_retry",    oRetry_Cnt, 32'd0);
        tickEn = 1'b1;
        repeat (5) cyc();

        // Single fault on bit 2, restart, 1000 ms backoff, back to RUN.
        pushExp(32'(S_RESTART)); pushExp(32'h04); pushExp(32'd1); pushExp(32'd0);
        pushExp(32'd8); pushExp(32'd8); pushExp(32'(S_BACKOFF));
        pushExp(32'd1000); pushExp(32'(S_RUN)); pushExp(32'd1);
        faultPulse(7'b0000100);
        popChk("t2_state_restart", oState);
        popChk("t2_first", oFirst_Flt);
        popChk("t2_retry", oRetry_Cnt);
        popChk("t2_en_restart", oSeq_En);
        waitLeave(S_RESTART, 100, tk, cy, lo);
        popChk("t2_rstn_low_cycles", lo);
        popChk("t2_restart_cycles", cy);
        popChk("t2_state_backoff", oState);
        waitLeave(S_BACKOFF, 10000, tk, cy, lo);
        popChk("t2_backoff_ticks", tk);
        popChk("t2_state_run", oState);
        popChk("t2_en_run", oSeq_En);

        // 10000 fault-free ticks in RUN clear the retry count but not the capture.
        pushExp(32'd1); pushExp(32'd0); pushExp(32'h04);
        n    = 0;
        done = 1'b0;
        for (int c = 0; c < 30000 && !done; c++) begin
            if (oState == S_RUN && iTick_1ms) begin
                n++;
                if (n == 10000) begin
                    popChk("t5_retry_at_9999", oRetry_Cnt);
                    cyc();
                    popChk("t5_retry_at_10000", oRetry_Cnt);
                    done = 1'b1;
                end
            end
            if (!done) cyc();
        end
        checkVal("t5_reached", {31'b0, done}, 32'd1);
        popChk("t5_first_kept", oFirst_Flt);

        // Three consecutive faults: backoffs 1000 and 2000 ms, then lockout.
        for (int k = 1; k <= 2; k++) begin
            pushExp(32'(k)); pushExp(32'(S_BACKOFF));
            pushExp(32'd1000 << (k - 1)); pushExp(32'(S_RUN));
            faultPulse(7'b0100000);
            popChk("t3_retry", oRetry_Cnt);
            waitLeave(S_RESTART, 100, tk, cy, lo);
            popChk("t3_state_backoff", oState);
            waitLeave(S_BACKOFF, 10000, tk, cy, lo);
            popChk("t3_backoff_ticks", tk);
            popChk("t3_state_run", oState);
        end
        pushExp(32'd3); pushExp(32'(S_LOCKOUT)); pushExp(32'd1); pushExp(32'd0);
        pushExp(32'h04); pushExp(32'(S_LOCKOUT));
        faultPulse(7'b0100000);
        waitLeave(S_RESTART, 100, tk, cy, lo);
        popChk("t3_retry_final", oRetry_Cnt);
        popChk("t3_state_lockout", oState);
        popChk("t3_lockout", oLockout);
        popChk("t3_en_lockout", oSeq_En);
        popChk("t3_first_kept", oFirst_Flt);
        repeat (20) cyc();
        popChk("t3_lockout_holds", oState);
        pushExp(32'(S_IDLE)); pushExp(32'd0); pushExp(32'd0); pushExp(32'd0);
        pushExp(32'(S_RUN));
        iClr_Lockout = 1'b1;
        cyc();
        iClr_Lockout = 1'b0;
        popChk("t3_clr_state", oState);
        popChk("t3_clr_lockout", oLockout);
        popChk("t3_clr_retry", oRetry_Cnt);
        popChk("t3_clr_first", oFirst_Flt);
        cyc();
        popChk("t3_rerun", oState);

        // Fault coinciding with request drop: RESTART wins, backoff then IDLE.
        repeat (3) cyc();
        pushExp(32'(S_RESTART)); pushExp(32'h01); pushExp(32'd1);
        pushExp(32'd1000); pushExp(32'(S_IDLE)); pushExp(32'd0);
        iPwr_Req = 1'b0;
        faultPulse(7'b0000001);
        popChk("t4_state_restart", oState);
        popChk("t4_first", oFirst_Flt);
        popChk("t4_retry", oRetry_Cnt);
        waitLeave(S_RESTART, 100, tk, cy, lo);
        waitLeave(S_BACKOFF, 10000, tk, cy, lo);
        popChk("t4_backoff_ticks", tk);
        popChk("t4_state_idle", oState);
        popChk("t4_en_idle", oSeq_En);

        // Clear coinciding with a new fault: the new capture wins.
        pushExp(32'(S_RUN));
        iPwr_Req = 1'b1;
        cyc();
        popChk("t4_idle_to_run", oState);
        pushExp(32'(S_RESTART)); pushExp(32'h08); pushExp(32'd2);
        iClr_Lockout = 1'b1;
        faultPulse(7'b0001000);
        iClr_Lockout = 1'b0;
        popChk("cc_state", oState);
        popChk("cc_first_new", oFirst_Flt);
        popChk("cc_retry", oRetry_Cnt);
        pushExp(32'(S_BACKOFF));
        waitLeave(S_RESTART, 100, tk, cy, lo);
        popChk("cc_state_backoff", oState);

        // A clear outside LOCKOUT drops only the fault capture.
        repeat (50) cyc();
        pushExp(32'd0); pushExp(32'd2); pushExp(32'(S_BACKOFF));
        iClr_Lockout = 1'b1;
        cyc();
        iClr_Lockout = 1'b0;
        popChk("clr_first", oFirst_Flt);
        popChk("clr_retry_kept", oRetry_Cnt);
        popChk("clr_state_kept", oState);

        // Asynchronous reset mid-backoff, then a fresh start with no retry history.
        repeat (20) cyc();
        pushExp(32'd0); pushExp(32'd0); pushExp(32'd0); pushExp(32'd0);
        pushExp(32'd0); pushExp(32'(S_IDLE));
        #2;
        iRst_n = 1'b0;
        #1;
        popChk("t6_en", oSeq_En);
        popChk("t6_rstn", oSeq_Rst_N);
        popChk("t6_retry", oRetry_Cnt);
        popChk("t6_first", oFirst_Flt);
        popChk("t6_lock", oLockout);
        popChk("t6_state", oState);
        repeat (2) cyc();
        iRst_n = 1'b1;
        pushExp(32'(S_IDLE)); pushExp(32'd1); pushExp(32'(S_RUN)); pushExp(32'd0);
        cyc();
        popChk("t6_state_c1", oState);
        popChk("t6_rstn_c1", oSeq_Rst_N);
        cyc();
        popChk("t6_state_c2", oState);
        popChk("t6_retry_c2", oRetry_Cnt);
        pushExp(32'd1); pushExp(32'd1000); pushExp(32'(S_RUN));
        repeat (4) cyc();
        faultPulse(7'b0000010);
        popChk("t6_retry_fresh", oRetry_Cnt);
        waitLeave(S_RESTART, 100, tk, cy, lo);
        waitLeave(S_BACKOFF, 10000, tk, cy, lo);
        popChk("t6_backoff_ticks", tk);
        popChk("t6_state_run", oState);

        checkVal("sb_drained", expQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
